l15_port_arbiter: RTL and testbench

//  Two-requester arbiter that shares the core's single L1.5 transducer port between instruction fetch (IFU) and

---
 rtl/l15_port_arbiter_if.sv | 32 +++
 rtl/l15_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_l15_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l15_port_arbiter_if.sv
// Request/response bundle for one side of the L1.5 transducer port.
// master = the side issuing requests and consuming responses; slave = the side serving them.
`default_nettype none

interface l15_port_arbiter_if #(
    parameter int ADDR_W = 40
);
    logic [4:0]        rqtype;
    logic [2:0]        size;
    logic [ADDR_W-1:0] address;
    logic [63:0]       data;
    logic              val;
    logic              ack;
    logic              header_ack;
    logic              resp_val;
    logic [3:0]        returntype;
    logic [63:0]       resp_data_0;
    logic [63:0]       resp_data_1;
    logic              req_ack;

    modport master (
        output rqtype, size, address, data, val, req_ack,
        input  ack, header_ack, resp_val, returntype, resp_data_0, resp_data_1
    );

    modport slave (
        input  rqtype, size, address, data, val, req_ack,
        output ack, header_ack, resp_val, returntype, resp_data_0, resp_data_1
    );
endinterface

`default_nettype wire

// File: rtl/l15_port_arbiter.sv
// Shares the single L1.5 transducer port between IFU and LSU: one registered request
// outstanding at a time, bounded LSU priority, response routed back to its owner.
`default_nettype none

module l15_port_arbiter #(
    parameter int ADDR_W    = 40,
    parameter int LSU_BURST = 4
) (
    input  wire logic          clk,
    input  wire logic          nrst,
    l15_port_arbiter_if.slave  ifu_if,
    l15_port_arbiter_if.slave  lsu_if,
    l15_port_arbiter_if.master l15_if,
    input  wire logic          ifu_kill,
    output logic               owner_lsu,
    output logic               spurious_resp
);

    localparam int BW = $clog2(LSU_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(LSU_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e            state_q;
    logic              owner_q;
    logic              val_q;
    logic              kill_q;
    logic              spurious_q;
    logic [BW-1:0]     burst_q;
    logic [4:0]        rqtype_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;

    logic is_idle, grant_lsu, grant_ifu, resp_phase, drain, route, own_rack, complete, hdr_fwd;

    // A response arriving together with the L1.5 accept is handled exactly like a WAIT response.
    always_comb begin
        is_idle    = (state_q == S_IDLE);
        grant_lsu  = is_idle && lsu_if.val && (!ifu_if.val || (burst_q < BURST_MAX));
        grant_ifu  = is_idle && ifu_if.val && !grant_lsu;
        resp_phase = (state_q == S_WAIT) || (state_q == S_DRAIN) ||
                     ((state_q == S_REQ) && l15_if.ack);
        drain      = (state_q == S_DRAIN) || (resp_phase && !owner_q && kill_q);
        route      = resp_phase && !drain;
        own_rack   = owner_q ? lsu_if.req_ack : ifu_if.req_ack;
        complete   = drain ? l15_if.resp_val : (route && l15_if.resp_val && own_rack);
        hdr_fwd    = ((state_q == S_REQ) || (state_q == S_WAIT)) && !(kill_q && !owner_q) &&
                     l15_if.header_ack;
    end

    assign ifu_if.ack         = grant_ifu;
    assign lsu_if.ack         = grant_lsu;
    assign ifu_if.header_ack  = hdr_fwd && !owner_q;
    assign lsu_if.header_ack  = hdr_fwd && owner_q;

    assign ifu_if.resp_val    = route && !owner_q && l15_if.resp_val;
    assign ifu_if.returntype  = (route && !owner_q) ? l15_if.returntype  : '0;
    assign ifu_if.resp_data_0 = (route && !owner_q) ? l15_if.resp_data_0 : '0;
    assign ifu_if.resp_data_1 = (route && !owner_q) ? l15_if.resp_data_1 : '0;
    assign lsu_if.resp_val    = route && owner_q && l15_if.resp_val;
    assign lsu_if.returntype  = (route && owner_q) ? l15_if.returntype  : '0;
    assign lsu_if.resp_data_0 = (route && owner_q) ? l15_if.resp_data_0 : '0;
    assign lsu_if.resp_data_1 = (route && owner_q) ? l15_if.resp_data_1 : '0;

    // Stray and drained responses are swallowed; routed ones wait for the owner.
    assign l15_if.req_ack = (is_idle || drain) ? l15_if.resp_val : (route && own_rack);

    assign l15_if.val     = val_q;
    assign l15_if.rqtype  = rqtype_q;
    assign l15_if.size    = size_q;
    assign l15_if.address = addr_q;
    assign l15_if.data    = data_q;
    assign owner_lsu      = owner_q;
    assign spurious_resp  = spurious_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            val_q      <= 1'b0;
            kill_q     <= 1'b0;
            spurious_q <= 1'b0;
            burst_q    <= '0;
            rqtype_q   <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (l15_if.resp_val) begin
                        spurious_q <= 1'b1;
                    end
                    if (grant_lsu || grant_ifu) begin
                        state_q  <= S_REQ;
                        val_q    <= 1'b1;
                        owner_q  <= grant_lsu;
                        kill_q   <= grant_ifu && ifu_kill;
                        rqtype_q <= grant_lsu ? lsu_if.rqtype  : ifu_if.rqtype;
                        size_q   <= grant_lsu ? lsu_if.size    : ifu_if.size;
                        addr_q   <= grant_lsu ? lsu_if.address : ifu_if.address;
                        data_q   <= grant_lsu ? lsu_if.data    : ifu_if.data;
                        if (grant_ifu) begin
                            burst_q <= '0;
                        end else if (ifu_if.val) begin
                            burst_q <= burst_q + BW'(1);
                        end
                    end
                end
                S_REQ: begin
                    if (ifu_kill && !owner_q) begin
                        kill_q <= 1'b1;
                    end
                    if (l15_if.ack) begin
                        val_q <= 1'b0;
                        if (complete) begin
                            state_q <= S_IDLE;
                            kill_q  <= 1'b0;
                        end else if (!owner_q && (kill_q || ifu_kill)) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (complete) begin
                        state_q <= S_IDLE;
                        kill_q  <= 1'b0;
                    end else if (ifu_kill && !owner_q) begin
                        state_q <= S_DRAIN;
                        kill_q  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (l15_if.resp_val) begin
                        state_q <= S_IDLE;
                        kill_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l15_port_arbiter.sv
// Self-checking bench for l15_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration and routing rules.
`default_nettype none

module tb_l15_port_arbiter;

    localparam int ADDR_W    = 40;
    localparam int LSU_BURST = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic ifu_kill = 1'b0;
    logic owner_lsu, spurious_resp;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   glog[$];

    l15_port_arbiter_if #(.ADDR_W(ADDR_W)) ifu_if ();
    l15_port_arbiter_if #(.ADDR_W(ADDR_W)) lsu_if ();
    l15_port_arbiter_if #(.ADDR_W(ADDR_W)) l15_if ();

    l15_port_arbiter #(.ADDR_W(ADDR_W), .LSU_BURST(LSU_BURST)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .ifu_if        (ifu_if),
        .lsu_if        (lsu_if),
        .l15_if        (l15_if),
        .ifu_kill      (ifu_kill),
        .owner_lsu     (owner_lsu),
        .spurious_resp (spurious_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ifu_if.rqtype = '0; ifu_if.size = '0; ifu_if.address = '0; ifu_if.data = '0;
        ifu_if.val = 1'b0; ifu_if.req_ack = 1'b0;
        lsu_if.rqtype = '0; lsu_if.size = '0; lsu_if.address = '0; lsu_if.data = '0;
        lsu_if.val = 1'b0; lsu_if.req_ack = 1'b0;
        l15_if.ack = 1'b0; l15_if.header_ack = 1'b0; l15_if.resp_val = 1'b0;
        l15_if.returntype = '0; l15_if.resp_data_0 = '0; l15_if.resp_data_1 = '0;
        ifu_kill = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    // L1.5 accepts the registered request, then responds; the owner withholds req_ack for
    // 'hold' cycles. Returns at the negedge of the first cycle after completion.
    task automatic serve(input bit own_l, input logic [63:0] d0, input int hold);
        @(negedge clk);
        l15_if.ack = 1'b1;
        #1 chk("srv_val_at_ack", 64'(l15_if.val), 64'd1);
        @(negedge clk);
        l15_if.ack = 1'b0;
        l15_if.resp_val = 1'b1; l15_if.resp_data_0 = d0; l15_if.resp_data_1 = ~d0;
        l15_if.returntype = 4'h5;
        #1 chk("srv_val_drop", 64'(l15_if.val), 64'd0);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            if (own_l) lsu_if.req_ack = (h == hold);
            else       ifu_if.req_ack = (h == hold);
            #1;
            chk("srv_own_rval", 64'(own_l ? lsu_if.resp_val : ifu_if.resp_val), 64'd1);
            chk("srv_own_d0", own_l ? lsu_if.resp_data_0 : ifu_if.resp_data_0, d0);
            chk("srv_own_d1", own_l ? lsu_if.resp_data_1 : ifu_if.resp_data_1, ~d0);
            chk("srv_oth_rval", 64'(own_l ? ifu_if.resp_val : lsu_if.resp_val), 64'd0);
            chk("srv_oth_d0", own_l ? ifu_if.resp_data_0 : lsu_if.resp_data_0, 64'd0);
            chk("srv_rack", 64'(l15_if.req_ack), 64'(h == hold));
            chk("srv_no_grant", 64'(ifu_if.ack | lsu_if.ack), 64'd0);
        end
        @(negedge clk);
        l15_if.resp_val = 1'b0; l15_if.resp_data_0 = '0; l15_if.resp_data_1 = '0;
        l15_if.returntype = '0;
        ifu_if.req_ack = 1'b0; lsu_if.req_ack = 1'b0;
    endtask

    // Randomized traffic; the model tracks one outstanding transaction and the fairness count.
    task automatic run(input int n, input int pi, input int pl);
        bit busy = 0, tval = 0, acked = 0, own_l = 0, rsp_on = 0, i_on = 0, l_on = 0;
        bit gi, gl, ack_now, own_rack, ha;
        int burst = 0, ack_dly = 0, rsp_dly = 0;
        logic [ADDR_W-1:0] e_addr = '0;
        logic [63:0] e_data = '0, r_d0 = '0;
        logic [7:0]  e_rs = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!i_on && ($urandom_range(99) < pi)) begin
                i_on = 1;
                ifu_if.address = ADDR_W'({$urandom, $urandom});
                ifu_if.data = {$urandom, $urandom};
                ifu_if.rqtype = 5'($urandom); ifu_if.size = 3'($urandom);
            end
            if (!l_on && ($urandom_range(99) < pl)) begin
                l_on = 1;
                lsu_if.address = ADDR_W'({$urandom, $urandom});
                lsu_if.data = {$urandom, $urandom};
                lsu_if.rqtype = 5'($urandom); lsu_if.size = 3'($urandom);
            end
            ifu_if.val = i_on; lsu_if.val = l_on;
            ack_now = tval && !acked && (ack_dly == 0);
            if (tval && !acked && ack_dly > 0) ack_dly--;
            l15_if.ack = ack_now;
            if (!rsp_on && (acked || ack_now)) begin
                if (rsp_dly == 0) begin
                    rsp_on = 1; r_d0 = {$urandom, $urandom};
                end else begin
                    rsp_dly--;
                end
            end
            l15_if.resp_val = rsp_on; l15_if.resp_data_0 = r_d0; l15_if.resp_data_1 = ~r_d0;
            ha = ($urandom_range(1) == 1);
            l15_if.header_ack = ha;
            ifu_if.req_ack = ($urandom_range(1) == 1);
            lsu_if.req_ack = ($urandom_range(1) == 1);
            #1;
            gl = !busy && l_on && (!i_on || burst < LSU_BURST);
            gi = !busy && i_on && !gl;
            own_rack = own_l ? lsu_if.req_ack : ifu_if.req_ack;
            chk("rnd_ifu_ack", 64'(ifu_if.ack), 64'(gi));
            chk("rnd_lsu_ack", 64'(lsu_if.ack), 64'(gl));
            chk("rnd_tr_val", 64'(l15_if.val), 64'(tval));
            chk("rnd_owner", 64'(owner_lsu), 64'(own_l));
            chk("rnd_ifu_hdr", 64'(ifu_if.header_ack), 64'(busy && !own_l && ha));
            chk("rnd_lsu_hdr", 64'(lsu_if.header_ack), 64'(busy && own_l && ha));
            if (tval) begin
                chk("rnd_tr_addr", 64'(l15_if.address), 64'(e_addr));
                chk("rnd_tr_data", l15_if.data, e_data);
                chk("rnd_tr_rqsz", 64'({l15_if.rqtype, l15_if.size}), 64'(e_rs));
            end
            chk("rnd_ifu_rval", 64'(ifu_if.resp_val), 64'(rsp_on && !own_l));
            chk("rnd_lsu_rval", 64'(lsu_if.resp_val), 64'(rsp_on && own_l));
            if (rsp_on) begin
                chk("rnd_rsp_d0", own_l ? lsu_if.resp_data_0 : ifu_if.resp_data_0, r_d0);
                chk("rnd_tr_rack", 64'(l15_if.req_ack), 64'(own_rack));
            end
            if (rsp_on && own_rack) begin
                rsp_on = 0; busy = 0; acked = 0;
            end else if (ack_now) begin
                acked = 1;
            end
            if (ack_now) tval = 0;
            if (gl || gi) begin
                busy = 1; tval = 1; own_l = gl;
                e_addr = gl ? lsu_if.address : ifu_if.address;
                e_data = gl ? lsu_if.data : ifu_if.data;
                e_rs   = gl ? {lsu_if.rqtype, lsu_if.size} : {ifu_if.rqtype, ifu_if.size};
                if (gi) begin
                    burst = 0; i_on = 0;
                end else begin
                    if (i_on) burst++;
                    l_on = 0;
                end
                ack_dly = int'($urandom_range(3));
                rsp_dly = int'($urandom_range(3));
                glog.push_back(gl);
            end
        end
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tr_val", 64'(l15_if.val), 64'd0);
        chk("rst_owner", 64'(owner_lsu), 64'd0);
        chk("rst_spurious", 64'(spurious_resp), 64'd0);
        chk("rst_tr_addr", 64'(l15_if.address), 64'd0);
        chk("rst_rack", 64'(l15_if.req_ack), 64'd0);
        nrst = 1'b1;

        // IFU alone: registered request one cycle after val, response back to IFU
        @(negedge clk);
        ifu_if.val = 1'b1; ifu_if.address = 40'h00_0000_1000; ifu_if.rqtype = 5'h3;
        ifu_if.size = 3'h2; ifu_if.data = 64'h55;
        #1 chk("t1_ifu_ack", 64'(ifu_if.ack), 64'd1);
        chk("t1_val_n", 64'(l15_if.val), 64'd0);
        @(negedge clk);
        ifu_if.val = 1'b0;
        #1 chk("t1_val_n1", 64'(l15_if.val), 64'd1);
        chk("t1_addr", 64'(l15_if.address), 64'h1000);
        chk("t1_rqtype", 64'(l15_if.rqtype), 64'h3);
        chk("t1_ack_pulse", 64'(ifu_if.ack), 64'd0);
        @(negedge clk);
        #1 chk("t1_val_n2", 64'(l15_if.val), 64'd1);
        serve(1'b0, 64'hDEAD_BEEF, 0);
        #1 chk("t1_idle_val", 64'(l15_if.val), 64'd0);

        // Simultaneous requests: LSU first, then IFU; IFU withholds req_ack while LSU waits
        @(negedge clk);
        ifu_if.val = 1'b1; ifu_if.address = 40'h11_0000_0040;
        lsu_if.val = 1'b1; lsu_if.address = 40'h22_0000_0080;
        #1 chk("t2_lsu_first", 64'(lsu_if.ack), 64'd1);
        chk("t2_ifu_waits", 64'(ifu_if.ack), 64'd0);
        @(negedge clk);
        lsu_if.val = 1'b0;
        #1 chk("t2_owner_l", 64'(owner_lsu), 64'd1);
        chk("t2_addr_l", 64'(l15_if.address), 64'h22_0000_0080);
        serve(1'b1, 64'hAAAA_0001, 0);
        #1 chk("t2_ifu_second", 64'(ifu_if.ack), 64'd1);
        @(negedge clk);
        ifu_if.val = 1'b0;
        lsu_if.val = 1'b1; lsu_if.address = 40'h33_0000_0100;
        #1 chk("t2_owner_i", 64'(owner_lsu), 64'd0);
        chk("t2_addr_i", 64'(l15_if.address), 64'h11_0000_0040);
        serve(1'b0, 64'hBBBB_0002, 3);
        #1 chk("t5_lsu_after", 64'(lsu_if.ack), 64'd1);
        @(negedge clk);
        lsu_if.val = 1'b0;
        serve(1'b1, 64'hCCCC_0003, 0);

        // Kill during WAIT: response drained, LSU proceeds afterwards
        @(negedge clk);
        ifu_if.val = 1'b1; ifu_if.address = 40'h44_0000_0000;
        #1 chk("t4_grant", 64'(ifu_if.ack), 64'd1);
        @(negedge clk);
        ifu_if.val = 1'b0; l15_if.ack = 1'b1;
        @(negedge clk);
        l15_if.ack = 1'b0; ifu_kill = 1'b1;
        #1 chk("t4_kill_nval", 64'(ifu_if.resp_val), 64'd0);
        @(negedge clk);
        ifu_kill = 1'b0; lsu_if.val = 1'b1; lsu_if.address = 40'h55_0000_0000;
        l15_if.resp_val = 1'b1; l15_if.resp_data_0 = 64'h1234;
        #1 chk("t4_drain_rval", 64'(ifu_if.resp_val), 64'd0);
        chk("t4_drain_d0", ifu_if.resp_data_0, 64'd0);
        chk("t4_drain_rack", 64'(l15_if.req_ack), 64'd1);
        chk("t4_drain_nogrant", 64'(lsu_if.ack), 64'd0);
        @(negedge clk);
        l15_if.resp_val = 1'b0; l15_if.resp_data_0 = '0;
        #1 chk("t4_lsu_grant", 64'(lsu_if.ack), 64'd1);
        @(negedge clk);
        lsu_if.val = 1'b0;
        #1 chk("t4_lsu_addr", 64'(l15_if.address), 64'h55_0000_0000);
        serve(1'b1, 64'h77, 0);

        // Spurious response in IDLE, then reset while LSU transaction is in WAIT
        l15_if.resp_val = 1'b1; l15_if.resp_data_0 = 64'h99;
        #1 chk("t6_sp_rack", 64'(l15_if.req_ack), 64'd1);
        chk("t6_sp_ifu_rval", 64'(ifu_if.resp_val), 64'd0);
        chk("t6_sp_lsu_rval", 64'(lsu_if.resp_val), 64'd0);
        @(negedge clk);
        l15_if.resp_val = 1'b0; l15_if.resp_data_0 = '0;
        lsu_if.val = 1'b1;
        #1 chk("t6_sticky", 64'(spurious_resp), 64'd1);
        @(negedge clk);
        lsu_if.val = 1'b0; l15_if.ack = 1'b1;
        @(negedge clk);
        l15_if.ack = 1'b0;
        #1 chk("t6_wait_owner", 64'(owner_lsu), 64'd1);
        nrst = 1'b0;
        #1 chk("t6_rst_owner", 64'(owner_lsu), 64'd0);
        chk("t6_rst_spur", 64'(spurious_resp), 64'd0);
        chk("t6_rst_val", 64'(l15_if.val), 64'd0);
        @(negedge clk);
        nrst = 1'b1; ifu_if.val = 1'b1;
        #1 chk("t6_idle_grant", 64'(ifu_if.ack), 64'd1);

        // Continuous LSU with IFU pending: LSU_BURST LSU grants then one IFU grant
        do_reset();
        glog.delete();
        run(60, 100, 100);
        chk("burst_count", 64'(glog.size() >= 10), 64'd1);
        for (int g = 0; g < 10 && g < glog.size(); g++)
            chk("burst_pattern", 64'(glog[g]), 64'((g % (LSU_BURST + 1)) != LSU_BURST));

        do_reset();
        run(3000, 40, 40);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
